// File: rtl/int_ctrl.sv
// Prioritised interrupt controller.
// Collects NUM_SRC interrupt lines into a pending register (per-source edge or
// level capture), arbitrates the enabled ones by fixed priority (index 0 wins)
// and hands the fetch unit a vector address through a req/ack handshake. It
// also produces the one-cycle save_regs / restore_regs pulses that bracket a
// handler. Handlers do not nest: while one runs, new requests only accumulate
// in the pending register.
module int_ctrl #(
  parameter int                NUM_SRC    = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0100),
  parameter int                VEC_STRIDE = 16,
  parameter int                ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,           // asynchronous, active-low
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] edge_mode,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               stall,
  input  logic               take_branch,
  input  logic               int_ack,
  input  logic               rti,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic               int_req,
  output logic [ADDR_W-1:0]  int_vector,
  output logic [ID_W-1:0]    int_id,
  output logic               save_regs,
  output logic               restore_regs,
  output logic               in_service
);

  // FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_RETURN  = 2'd3;

  // State
  logic [1:0]         state_q,    state_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q,  pending_d;
  logic [NUM_SRC-1:0] mask_q,     mask_d;
  logic [ID_W-1:0]    int_id_q,   int_id_d;
  logic [ADDR_W-1:0]  int_vec_q,  int_vec_d;
  logic               save_q,     save_d;

  // Combinational helpers
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] svc_onehot;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    win_id;
  logic [ADDR_W-1:0]  win_vec;
  logic               grant;
  logic               ack_fire;

  // Only enabled pending sources take part in arbitration; the mask is read
  // from its register, so a mask write affects arbitration one cycle later.
  assign eligible = pending_q & mask_q;

  // Rising edge relative to the value registered on the previous clock.
  assign rise = irq_src & ~irq_prev_q;

  // Fixed-priority encoder: lowest set index wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Vector address of the winner; wraps modulo 2^ADDR_W by construction.
  assign win_vec = VEC_BASE + ADDR_W'(win_id) * ADDR_W'(VEC_STRIDE);

  // One-hot decode of the source currently latched for service.
  always_comb begin
    svc_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      svc_onehot[i] = (int_id_q == ID_W'(i));
    end
  end

  // Handshake FSM: IDLE -> REQ -> SERVICE -> RETURN -> IDLE.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    ack_fire = 1'b0;
    save_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Stalls and branches in MEM hold off a new request; pending keeps it.
        if ((|eligible) && !stall && !take_branch) begin
          grant   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Request is held stable until fetch acknowledges it.
        if (int_ack) begin
          ack_fire = 1'b1;
          save_d   = 1'b1;
          state_d  = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (rti) state_d = S_RETURN;
      end
      S_RETURN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The serviced source is cleared on the ack edge.
  assign clr = ack_fire ? svc_onehot : '0;

  // Pending next state: edge sources set on a rise (set beats clear), level
  // sources simply follow the registered line. Masking never clears pending.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_mode[i]) pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
      else              pending_d[i] = irq_src[i];
    end
  end

  // Mask register next state.
  assign mask_d = mask_we ? mask_wdata : mask_q;

  // Request id/vector are captured at grant and held until the next grant.
  assign int_id_d  = grant ? win_id  : int_id_q;
  assign int_vec_d = grant ? win_vec : int_vec_q;

  // All state registers; mask resets to all-enabled, everything else to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      int_id_q   <= '0;
      int_vec_q  <= '0;
      save_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      irq_prev_q <= irq_src;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      int_id_q   <= int_id_d;
      int_vec_q  <= int_vec_d;
      save_q     <= save_d;
    end
  end

  // Outputs decode directly from registered state.
  assign mask         = mask_q;
  assign pending      = pending_q;
  assign int_req      = (state_q == S_REQ);
  assign int_id       = int_id_q;
  assign int_vector   = int_vec_q;
  assign save_regs    = save_q;
  assign restore_regs = (state_q == S_RETURN);
  assign in_service   = (state_q == S_SERVICE);

endmodule
